// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Control FSM and local storage for the UART matrix-multiply path.
//   The sequencer accepts a byte stream of M, N, P, then A (M x N, row-major),
//   then B (N x P, row-major). It computes C = A x B with one multiply-accumulate
//   per cycle and returns C row-major, three bytes per entry, MSB first, using
//   the transmitter's busy handshake. If a dimension is out of range, it pulses
//   err and sends ERR_BYTE instead.
//
// Ports
//   clk       system clock (rising edge)
//   rst       asynchronous active-high reset
//   rx_data   received byte, valid while rx_valid=1
//   rx_valid  one-cycle strobe per received byte
//   tx_busy   transmitter busy flag
//   tx_data   byte to transmit, held from tx_start until tx_busy falls
//   tx_start  one-cycle transmit request
//   busy      high in every state except IDLE
//   done      one-cycle pulse when the last result byte has completed
//   err       one-cycle pulse when a dimension is rejected
module matmul_sequencer #(
  parameter int unsigned MAX_M    = 4,
  parameter int unsigned MAX_N    = 4,
  parameter int unsigned MAX_P    = 4,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int NW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_N, S_GET_P, S_LOAD_A, S_LOAD_B, S_COMPUTE,
    S_SEND, S_WAIT_HI, S_WAIT_LO, S_ERR_SEND, S_ERR_WAIT_HI, S_ERR_WAIT_LO
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      m_q, m_d, n_q, n_d;
  logic [MW-1:0]   m_last_q, m_last_d, i_q, i_d;
  logic [NW-1:0]   n_last_q, n_last_d, k_q, k_d;
  logic [PW-1:0]   p_last_q, p_last_d, j_q, j_d;
  logic [1:0]      b_q, b_d;
  logic [23:0]     acc_q, acc_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d, done_q, done_d, err_q, err_d;
  logic            a_we, b_we, c_we;

  logic [7:0]  a_mem [MAX_M][MAX_N];
  logic [7:0]  b_mem [MAX_N][MAX_P];
  logic [23:0] c_mem [MAX_M][MAX_P];

  // Datapath: A and B are addressed by (i,k) and (k,j) during loading and during compute.
  // C is addressed by (i,j) during compute and during send.
  logic [15:0] prod;
  logic [23:0] mac_sum, c_word;
  logic [7:0]  c_byte;
  logic        i_last, j_last, k_last, dims_ok;

  assign prod    = {8'd0, a_mem[i_q][k_q]} * {8'd0, b_mem[k_q][j_q]};
  assign mac_sum = ((k_q == '0) ? 24'd0 : acc_q) + {8'd0, prod};
  assign c_word  = c_mem[i_q][j_q];
  assign i_last  = (i_q == m_last_q);
  assign j_last  = (j_q == p_last_q);
  assign k_last  = (k_q == n_last_q);

  // The check uses the full received byte. The indices therefore never see an out-of-range value.
  assign dims_ok = (m_q != 8'd0) && (m_q <= 8'(MAX_M)) &&
                   (n_q != 8'd0) && (n_q <= 8'(MAX_N)) &&
                   (rx_data != 8'd0) && (rx_data <= 8'(MAX_P));

  always_comb begin
    case (b_q)
      2'd0:    c_byte = c_word[23:16];
      2'd1:    c_byte = c_word[15:8];
      default: c_byte = c_word[7:0];
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    m_last_d   = m_last_q;
    n_last_d   = n_last_q;
    p_last_d   = p_last_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    b_d        = b_q;
    acc_d      = acc_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    c_we       = 1'b0;

    case (state_q)
      S_IDLE: if (rx_valid) begin
        m_d     = rx_data;
        state_d = S_GET_N;
      end
      S_GET_N: if (rx_valid) begin
        n_d     = rx_data;
        state_d = S_GET_P;
      end
      S_GET_P: if (rx_valid) begin
        if (dims_ok) begin
          m_last_d = MW'(m_q - 8'd1);
          n_last_d = NW'(n_q - 8'd1);
          p_last_d = PW'(rx_data - 8'd1);
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          state_d  = S_LOAD_A;
        end else begin
          err_d    = 1'b1;
          state_d  = S_ERR_SEND;
        end
      end
      S_LOAD_A: if (rx_valid) begin
        a_we = 1'b1;
        if (!k_last) k_d = k_q + NW'(1);
        else begin
          k_d = '0;
          if (!i_last) i_d = i_q + MW'(1);
          else begin
            i_d     = '0;
            state_d = S_LOAD_B;
          end
        end
      end
      S_LOAD_B: if (rx_valid) begin
        b_we = 1'b1;
        if (!j_last) j_d = j_q + PW'(1);
        else begin
          j_d = '0;
          if (!k_last) k_d = k_q + NW'(1);
          else begin
            k_d     = '0;
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        // Loop order is i, then j, then k, with k innermost. C[i][j] is written on the last k.
        acc_d = mac_sum;
        if (!k_last) k_d = k_q + NW'(1);
        else begin
          c_we = 1'b1;
          k_d  = '0;
          if (!j_last) j_d = j_q + PW'(1);
          else begin
            j_d = '0;
            if (!i_last) i_d = i_q + MW'(1);
            else begin
              i_d     = '0;
              b_d     = 2'd0;
              state_d = S_SEND;
            end
          end
        end
      end
      S_SEND: if (!tx_busy) begin
        tx_data_d  = c_byte;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!tx_busy) begin
        state_d = S_SEND;
        if (b_q != 2'd2) b_d = b_q + 2'd1;
        else begin
          b_d = 2'd0;
          if (!j_last) j_d = j_q + PW'(1);
          else begin
            j_d = '0;
            if (!i_last) i_d = i_q + MW'(1);
            else begin
              i_d     = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_ERR_SEND: if (!tx_busy) begin
        tx_data_d  = ERR_BYTE;
        tx_start_d = 1'b1;
        state_d    = S_ERR_WAIT_HI;
      end
      S_ERR_WAIT_HI: if (tx_busy)  state_d = S_ERR_WAIT_LO;
      S_ERR_WAIT_LO: if (!tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      m_last_q   <= '0;
      n_last_q   <= '0;
      p_last_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      m_last_q   <= m_last_d;
      n_last_q   <= n_last_d;
      p_last_q   <= p_last_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the matrix storage has no reset. Every entry is written before it is read within a frame,
  // so the storage can map onto plain RAM or register files.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[i_q][k_q] <= rx_data;
    if (b_we) b_mem[k_q][j_q] <= rx_data;
    if (c_we) c_mem[i_q][j_q] <= mac_sum;
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Control FSM and local storage for the UART matrix-multiply path.
- Parses a byte stream from the UART receiver: dimensions, then matrix A, then matrix B.
- Computes C = A×B with one multiply-accumulate per cycle, then streams C back through the UART transmitter using its busy handshake.
- Sits between the uartRX and uartTX instances inside the matrix loader top level. The C array is internal and is never exported.

Parameters:
- MAX_M, 4, maximum rows of A (range 1..15).
- MAX_N, 4, maximum columns of A and rows of B (range 1..15).
- MAX_P, 4, maximum columns of B (range 1..15).
- ERR_BYTE, 8'hEE, byte transmitted when a dimension is rejected.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle pulse per received byte.
- tx_busy  input  1  transmitter busy flag.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle transmit request.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last result byte completes.
- err  output  1  one-cycle pulse when a dimension is rejected.

Behaviour:
- Reset (async, any state): state=IDLE; tx_data=0; tx_start=0; busy=0; done=0; err=0; all indices cleared. A/B/C contents are don't-care.
- Elements: 8-bit unsigned. Products: 16-bit. Accumulator and C entries: 24-bit unsigned, with no overflow possible within the parameter limits.
- Order: A and B are loaded row-major. C is sent row-major, 3 bytes per entry, MSB first.
- IDLE: on rx_valid, latch M=rx_data, go to GET_N.
- GET_N: on rx_valid, latch N, go to GET_P.
- GET_P: on rx_valid, latch P. Check 1≤M≤MAX_M, 1≤N≤MAX_N, 1≤P≤MAX_P.
  - Pass: go to LOAD_A.
  - Fail: pulse err, go to ERR_SEND.
- LOAD_A: each rx_valid writes A[r][c], advancing c then r. After M*N bytes, go to LOAD_B.
- LOAD_B: each rx_valid writes B. After N*P bytes, go to COMPUTE on the next cycle.
- COMPUTE: iterate i (0..M-1), j (0..P-1), k (0..N-1).
  - Each cycle: acc ← (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - On k==N-1: C[i][j] ← final sum.
  - Exactly M*P*N cycles, then go to SEND.
- SEND: if tx_busy=0, drive tx_data with the current C byte, pulse tx_start for one cycle, go to WAIT_HI.
- WAIT_HI: stay until tx_busy=1, then go to WAIT_LO.
- WAIT_LO: stay until tx_busy=0. Then:
  - If more bytes remain, advance the byte index and return to SEND.
  - Otherwise pulse done and go to IDLE.
- ERR_SEND / ERR_WAIT: identical handshake sending ERR_BYTE, then go to IDLE. No done pulse.
- rx_valid in COMPUTE, SEND, WAIT_*, or ERR_* is dropped. It has no effect on any state or data.
- tx_start is never asserted while tx_busy=1. There is at most one outstanding byte at a time.
- tx_busy held high indefinitely: the FSM stalls in WAIT_LO with no timeout.
- Reset asserted mid-load or mid-send: the FSM aborts immediately and the next frame starts fresh from IDLE.
- Back-to-back frames: a new M byte is accepted on the cycle after done.

Test Plan:
- Frame 01 01 01 03 05 -> COMPUTE lasts 1 cycle; TX bytes 00 00 0F; done pulses once; busy returns to 0.
- Frame 02 02 02, A=01 02 03 04, B=01 00 00 01 (identity) -> TX 000001 000002 000003 000004 (12 bytes); COMPUTE lasts 8 cycles.
- Frame 04 04 04, all A and B bytes FF -> 16 entries each 03 F8 04 (48 bytes); COMPUTE lasts 64 cycles.
- Frame 00 02 02, then 05 01 01 -> err pulses after each P byte; TX EE once per frame; FSM in IDLE after each; no A/B bytes consumed.
- Reset asserted after 3 of 4 A bytes in a 2x2x2 frame, then a full 1x1x1 frame 01 01 01 02 07 -> TX 00 00 0E only.
- Bench holds tx_busy high for 1000 cycles after the first result byte; extra rx_valid pulses injected during SEND -> tx_start never fires while busy; output bytes unchanged; stray bytes ignored.
